// File: rtl/vram_rect_writer_if.sv
// -----------------------------------------------------------------------------
// vram_rect_writer_if
//   Bundles the two buses of the rectangle writer:
//     command side : cmd_valid/cmd_ready handshake plus the rectangle fields
//     VRAM side    : vram_we/vram_wready write request with address and data
//   master modport : the command source / VRAM model (drives commands, wready)
//   slave  modport : the rectangle writer itself
// -----------------------------------------------------------------------------
interface vram_rect_writer_if #(
  parameter int AW = 19,
  parameter int DW = 12
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_clear;
  logic [9:0]    cmd_x;
  logic [9:0]    cmd_y;
  logic [9:0]    cmd_w;
  logic [9:0]    cmd_h;
  logic [DW-1:0] cmd_color;
  logic          vram_we;
  logic          vram_wready;
  logic [AW-1:0] vram_waddr;
  logic [DW-1:0] vram_wdata;

  modport master (
    output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    output vram_wready,
    input  cmd_ready, vram_we, vram_waddr, vram_wdata
  );

  modport slave (
    input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
    input  vram_wready,
    output cmd_ready, vram_we, vram_waddr, vram_wdata
  );
endinterface

// File: rtl/vram_rect_writer.sv
// -----------------------------------------------------------------------------
// vram_rect_writer
//   Write side of the 640x480x12 frame buffer. Accepts one rectangle-fill
//   command at a time, clips it to the visible area and streams one pixel
//   write per accepted cycle in raster order at address row*640+col.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     bus        : vram_rect_writer_if.slave (command handshake + VRAM write)
//     busy_o     : a command is in SETUP, DRAW or DONE
//     done_o     : one-cycle pulse when a command completes
// -----------------------------------------------------------------------------
module vram_rect_writer #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19,
  parameter int DW    = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  vram_rect_writer_if.slave  bus,
  output logic               busy_o,
  output logic               done_o
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_DRAW, S_DONE} state_e;

  localparam logic [10:0]   H_END  = 11'(H_RES);
  localparam logic [10:0]   V_END  = 11'(V_RES);
  localparam logic [AW-1:0] STRIDE = AW'(H_RES);

  state_e state_q, state_d;

  // Latched command fields.
  logic          clear_q;
  logic [9:0]    x_q, y_q, w_q, h_q;
  logic [DW-1:0] color_q;

  // Clipped bounds and raster walk position.
  logic [10:0]   xs_q, xe_q, ye_q;
  logic [10:0]   col_q, row_q;
  logic [AW-1:0] base_q, addr_q;

  // SETUP-cycle clipping (11-bit, so x+w never wraps).
  logic [10:0]   x_s, y_s, x_sum, y_sum, x_e, y_e;
  logic [AW-1:0] start_addr;
  logic          empty;
  logic          last_col, last_row;

  always_comb begin
    x_s   = clear_q ? 11'd0 : {1'b0, x_q};
    y_s   = clear_q ? 11'd0 : {1'b0, y_q};
    x_sum = {1'b0, x_q} + {1'b0, w_q};
    y_sum = {1'b0, y_q} + {1'b0, h_q};
    x_e   = clear_q ? H_END : ((x_sum > H_END) ? H_END : x_sum);
    y_e   = clear_q ? V_END : ((y_sum > V_END) ? V_END : y_sum);
    empty = !clear_q && (({1'b0, x_q} >= H_END) || ({1'b0, y_q} >= V_END) ||
                         (w_q == 10'd0) || (h_q == 10'd0));
    // y*640 as two shifts; the only multiply-like term, evaluated once per
    // command rather than per pixel.
    start_addr = (AW'(y_s) << 9) + (AW'(y_s) << 7) + AW'(x_s);
    last_col   = (col_q == (xe_q - 11'd1));
    last_row   = (row_q == (ye_q - 11'd1));
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    bus.cmd_ready  = 1'b0;
    bus.vram_we    = 1'b0;
    busy_o         = 1'b1;
    done_o         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.cmd_ready = 1'b1;
        busy_o        = 1'b0;
        if (bus.cmd_valid) state_d = S_SETUP;
      end
      S_SETUP: state_d = empty ? S_DONE : S_DRAW;
      S_DRAW: begin
        bus.vram_we = 1'b1;
        if (bus.vram_wready && last_col && last_row) state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the whole datapath is reset, not just the FSM, because waddr and
  // wdata are visible outputs with a defined reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clear_q <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      xs_q    <= '0;
      xe_q    <= '0;
      ye_q    <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // samples the pre-edge values of its neighbours regardless of order.
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            clear_q <= bus.cmd_clear;
            x_q     <= bus.cmd_x;
            y_q     <= bus.cmd_y;
            w_q     <= bus.cmd_w;
            h_q     <= bus.cmd_h;
            color_q <= bus.cmd_color;
          end
        end
        S_SETUP: begin
          xs_q  <= x_s;
          xe_q  <= x_e;
          ye_q  <= y_e;
          col_q <= x_s;
          row_q <= y_s;
          // An empty command never loads the address, so out-of-range starts
          // are never driven onto the bus.
          if (!empty) begin
            base_q <= start_addr;
            addr_q <= start_addr;
          end
        end
        S_DRAW: begin
          if (bus.vram_wready) begin
            if (!last_col) begin
              col_q  <= col_q + 11'd1;
              addr_q <= addr_q + AW'(1);
            end else if (!last_row) begin
              col_q  <= xs_q;
              row_q  <= row_q + 11'd1;
              base_q <= base_q + STRIDE;
              addr_q <= base_q + STRIDE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.vram_waddr = addr_q;
  assign bus.vram_wdata = color_q;

endmodule

// File: tb/tb_vram_rect_writer.sv
// -----------------------------------------------------------------------------
// tb_vram_rect_writer
//   Drives rectangle commands through the interface, models the expected
//   raster of writes as a plain list of row*640+col addresses, and compares
//   every accepted write, stall, handshake and done timing against it.
// -----------------------------------------------------------------------------
module tb_vram_rect_writer;
  localparam int H = 640;
  localparam int V = 480;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, done;

  vram_rect_writer_if #(.AW(19), .DW(12)) bus ();

  vram_rect_writer #(.H_RES(H), .V_RES(V), .AW(19), .DW(12)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .busy_o (busy),
    .done_o (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int wr_pat[$];
  int stall_pct = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit pick_wready();
    if (wr_pat.size() > 0) return wr_pat.pop_front() != 0;
    return $urandom_range(99) >= stall_pct;
  endfunction

  // Issues one command and follows it to completion (or aborts it with a
  // reset after abort_after accepted writes when abort_after > 0).
  task automatic run_cmd(input bit clr, input int x, input int y, input int w,
                         input int h, input int color, input int abort_after);
    int exp_a[$];
    int xs, ys, xe, ye, exp_n, budget;
    int k, n_wr, last_k, first_k, a;
    bit stalled, wr, finished, aborted;
    logic [18:0] st_a;
    logic [11:0] st_d;

    if (clr) begin
      xs = 0; ys = 0; xe = H; ye = V;
    end else begin
      xs = x; ys = y;
      xe = (x + w < H) ? x + w : H;
      ye = (y + h < V) ? y + h : V;
      if (x >= H || y >= V || w == 0 || h == 0) xe = xs;
    end
    for (int r = ys; r < ye; r++)
      for (int c = xs; c < xe; c++)
        exp_a.push_back(r * H + c);
    exp_n  = exp_a.size();
    budget = 4 * exp_n + 20;

    check("ready_idle", {31'd0, bus.cmd_ready}, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_clear = clr;
    bus.cmd_x     = 10'(x);
    bus.cmd_y     = 10'(y);
    bus.cmd_w     = 10'(w);
    bus.cmd_h     = 10'(h);
    bus.cmd_color = 12'(color);
    @(negedge clk);
    // Accepted on the edge just passed: scramble the fields and keep valid
    // high; the block must neither re-latch nor queue them.
    bus.cmd_clear = 1'($urandom);
    bus.cmd_x     = 10'($urandom);
    bus.cmd_y     = 10'($urandom);
    bus.cmd_w     = 10'($urandom);
    bus.cmd_h     = 10'($urandom);
    bus.cmd_color = 12'($urandom);

    k = 1; n_wr = 0; last_k = 0; first_k = 0;
    stalled = 0; finished = 0; aborted = 0;
    while (!finished && k <= budget) begin
      check("busy", {31'd0, busy}, 1);
      check("ready_busy", {31'd0, bus.cmd_ready}, 0);
      if (stalled) begin
        check("stall_addr", 32'(bus.vram_waddr), 32'(st_a));
        check("stall_data", 32'(bus.vram_wdata), 32'(st_d));
      end
      stalled = 0;
      if (done) begin
        check("done_cycle", k, (exp_n == 0) ? 2 : last_k + 1);
        check("n_writes", n_wr, exp_n);
        check("we_in_done", {31'd0, bus.vram_we}, 0);
        bus.cmd_valid = 1'b0;
        finished = 1;
      end else begin
        wr = bus.vram_we ? pick_wready() : 1'($urandom);
        bus.vram_wready = wr;
        if (bus.vram_we) begin
          if (first_k == 0) begin
            first_k = k;
            check("first_we", k, 2);
          end
          if (wr) begin
            if (exp_a.size() == 0) begin
              check("extra_write", 32'(bus.vram_waddr), 32'hFFFF_FFFF);
            end else begin
              a = exp_a.pop_front();
              check("waddr", 32'(bus.vram_waddr), a);
              check("wdata", 32'(bus.vram_wdata), 32'(color & 'hFFF));
            end
            n_wr++;
            last_k = k;
          end else begin
            stalled = 1;
            st_a = bus.vram_waddr;
            st_d = bus.vram_wdata;
          end
        end
        if (abort_after > 0 && n_wr == abort_after) begin
          aborted  = 1;
          finished = 1;
        end
        @(negedge clk);
        k++;
      end
    end
    if (!finished) check("timeout", 0, 1);

    if (aborted) begin
      #2 rst_n = 1'b0;
      #1;
      check("abort_we", {31'd0, bus.vram_we}, 0);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_done", {31'd0, done}, 0);
      check("abort_nwr", n_wr, abort_after);
      bus.cmd_valid   = 1'b0;
      bus.vram_wready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        check("abort_rst_done", {31'd0, done}, 0);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
        @(negedge clk);
        check("abort_ready", {31'd0, bus.cmd_ready}, 1);
        check("abort_post_done", {31'd0, done}, 0);
        check("abort_post_we", {31'd0, bus.vram_we}, 0);
      end
    end else begin
      bus.vram_wready = 1'b1;
      @(negedge clk);
      check("post_ready", {31'd0, bus.cmd_ready}, 1);
      check("post_busy", {31'd0, busy}, 0);
      check("post_done", {31'd0, done}, 0);
    end
  endtask

  initial begin
    int rx, ry, rw, rh;
    bus.cmd_valid   = 1'b0;
    bus.cmd_clear   = 1'b0;
    bus.cmd_x       = '0;
    bus.cmd_y       = '0;
    bus.cmd_w       = '0;
    bus.cmd_h       = '0;
    bus.cmd_color   = '0;
    bus.vram_wready = 1'b1;

    // Reset held for three cycles, then idle.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_we", {31'd0, bus.vram_we}, 0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("idle_ready", {31'd0, bus.cmd_ready}, 1);
      check("idle_busy", {31'd0, busy}, 0);
      check("idle_we", {31'd0, bus.vram_we}, 0);
      check("idle_done", {31'd0, done}, 0);
      check("idle_waddr", 32'(bus.vram_waddr), 0);
      check("idle_wdata", 32'(bus.vram_wdata), 0);
    end

    // Directed cases.
    run_cmd(0, 10, 2, 3, 2, 'hF00, 0);
    run_cmd(0, 638, 479, 5, 4, 'h5A3, 0);
    run_cmd(0, 640, 5, 1, 1, 'h111, 0);
    run_cmd(0, 5, 5, 0, 3, 'h222, 0);
    run_cmd(0, 5, 5, 3, 0, 'h333, 0);
    run_cmd(0, 5, 480, 3, 3, 'h444, 0);
    run_cmd(0, 0, 0, 1023, 1, 'h0F0, 0);
    wr_pat = '{1, 0, 0, 1, 1, 0, 1};
    run_cmd(0, 100, 50, 4, 1, 'h0A5, 0);
    wr_pat.delete();

    // Randomized rectangles, biased towards the right and bottom edges.
    stall_pct = 30;
    for (int n = 0; n < 60; n++) begin
      rx = ($urandom_range(3) == 0) ? $urandom_range(600, 700) : $urandom_range(0, 639);
      ry = ($urandom_range(3) == 0) ? $urandom_range(460, 520) : $urandom_range(0, 479);
      rw = $urandom_range(0, 20);
      rh = $urandom_range(0, 20);
      run_cmd(0, rx, ry, rw, rh, $urandom_range(0, 4095), 0);
    end

    // Full-screen clear aborted by reset after 1000 writes, then recovery.
    stall_pct = 0;
    run_cmd(1, 123, 45, 6, 7, 0, 1000);
    run_cmd(0, 0, 0, 2, 2, 'h123, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop in case a wait inside the bench itself never returns.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/vram_rect_writer.md
Name: vram_rect_writer

Overview:
- Write side of the 640x480, 12-bit frame buffer that the VGA scan-out block reads.
- Accepts rectangle-fill commands from the game/CPU logic, clips each rectangle to the visible area, and streams one pixel write per cycle into the VRAM write port at address row*640+col.
- Drawing tanks, bullets and tiles, and clearing the screen, all go through this block.

Parameters:
- H_RES, 640, visible columns; also the row stride in words.
- V_RES, 480, visible rows.
- AW, 19, VRAM address width.
- DW, 12, pixel width; bits [3:0]=R, [7:4]=G, [11:8]=B, the same packing the scan-out uses.

Ports:
- clk  in  1  pixel/system clock.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_clear  in  1  1 = full-screen fill; overrides x/y/w/h.
- cmd_x  in  10  left column.
- cmd_y  in  10  top row.
- cmd_w  in  10  width in pixels.
- cmd_h  in  10  height in rows.
- cmd_color  in  DW  fill colour.
- vram_we  out  1  write request.
- vram_wready  in  1  VRAM/arbiter accepts the write this cycle.
- vram_waddr  out  AW  write address.
- vram_wdata  out  DW  write data.
- busy  out  1  a command is in progress.
- done  out  1  one-cycle pulse when a command completes.

Behaviour:
- Reset (async, rst_n=0): state IDLE; cmd_ready=1, vram_we=0, vram_waddr=0, vram_wdata=0, busy=0, done=0.
- Command accept: handshake cmd_valid&cmd_ready, which can occur only in IDLE. All cmd_* fields are latched on that edge; later changes are ignored.
- cmd_ready=1 only in IDLE.
- busy=1 in SETUP, DRAW and DONE.
- FSM:
  - IDLE -> SETUP on accept.
  - SETUP, one cycle: compute clipped bounds and the start address.
    - Go to DONE if the clipped area is empty.
    - Otherwise go to DRAW.
  - DRAW: vram_we=1. Step to the next pixel only on a cycle where vram_we&vram_wready. While wready=0, waddr and wdata hold stable.
  - DONE, one cycle: done=1, vram_we=0, then IDLE.
- Clipping, using 11-bit arithmetic with no wrap:
  - x_end = min(x+w, H_RES); y_end = min(y+h, V_RES).
  - The area is empty if x>=H_RES, y>=V_RES, w==0 or h==0.
- cmd_clear=1: x=0, y=0, x_end=H_RES, y_end=V_RES, regardless of the other fields.
- Addressing: no multiplier in the per-pixel path.
  - Start address = y*512 + y*128 + x, computed in SETUP.
  - Within a row the address increments by 1.
  - On the last column of a row: row_base += H_RES, and the address reloads to row_base.
  - Raster order: left to right, then top to bottom.
- Latency:
  - Accept at edge T; first vram_we at T+2 (after the SETUP cycle).
  - With wready held high, N clipped pixels occupy N consecutive cycles.
  - done is asserted the cycle after the last accepted write.
  - Next command can be accepted the cycle after done.
- Empty command: done one cycle after SETUP, i.e. at T+2; no vram_we.
- Last pixel: bottom-right (639,479) has address 307199. No address above 307199 is ever driven.
- Reset mid-draw: writing aborts immediately with vram_we=0. The partial rectangle is left in VRAM and there is no done pulse.
- cmd_valid asserted while busy: ignored and not queued; it is accepted once the block returns to IDLE.

Test Plan:
- Reset, then idle: rst_n low for 3 cycles, release -> cmd_ready=1, busy=0, vram_we=0; no done.
- Small fill, wready=1: x=10, y=2, w=3, h=2, color=12'hF00 -> 6 writes at addresses 1290,1291,1292,1930,1931,1932, all data F00. First write at T+2; done at T+8.
- Clipping: x=638, y=479, w=5, h=4 -> exactly 2 writes, addresses 307198 and 307199. Then done.
- Empty commands: x=640, w=1, h=1; then, separately, w=0 -> no vram_we; done 2 cycles after accept.
- Backpressure: 4x1 fill with wready toggling 1,0,0,1,1,0,1 -> waddr/wdata stable during stalls; exactly 4 distinct sequential addresses; done follows the 4th accepted write.
- Clear plus mid-operation reset: cmd_clear=1, color=0 -> 307200 writes from 0 to 307199 with done at the end. A repeat with rst_n pulsed low after 1000 writes -> vram_we drops asynchronously, no done, and cmd_ready=1 after release.
